// File: rtl/poly_mult_dummy_sched.sv
// Purpose: drives the poly_mult core with the real job hidden among N random dummy jobs; returns only the real result.
// Latency: per job 4 draw + 1 launch + ARM/RUN (>=2) + 1 next cycles; done_o one cycle after the last job's NEXT.
// Backpressure: none upstream; start_i outside IDLE is dropped, core completion is tracked via core_busy_i.
module poly_mult_dummy_sched #(
  parameter int          DATA_W = 128,
  parameter int          KEY_W  = 128,
  parameter int          DCNT_W = 3,
  parameter logic [31:0] SEED   = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              dummy_en_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              seed_we_i,
  input  logic [31:0]       seed_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              core_load_o,
  output logic [KEY_W-1:0]  core_key_o,
  output logic [DATA_W-1:0] core_data_o,
  input  logic              core_busy_i,
  input  logic [DATA_W-1:0] core_res_i
);

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam int          HALF = DATA_W / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW, S_LAUNCH, S_ARM, S_RUN, S_NEXT, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DATA_W-1:0]   dmy_q, dmy_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DCNT_W-1:0]   n_q, n_d;
  logic [DCNT_W-1:0]   p_q, p_d;
  logic [DCNT_W-1:0]   slot_q, slot_d;
  logic [1:0]          draw_cnt_q, draw_cnt_d;
  logic                arm_cnt_q, arm_cnt_d;

  logic [31:0]         lfsr_step;
  logic [DCNT_W-1:0]   n_sel;
  logic [DCNT_W-1:0]   p_sel;
  logic [7:0]          mod_div;
  logic                is_real;
  logic                ops_active;
  logic [KEY_W-1:0]    dummy_key;

  // Random draws for a new start: dummy count and real-job slot
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
    n_sel     = dummy_en_i ? lfsr_q[DCNT_W-1:0] : '0;
    mod_div   = 8'(n_sel) + 8'd1;
    p_sel     = DCNT_W'(lfsr_q[15:8] % mod_div);
  end

  // Core-facing operand mux; dummy key is the dummy operand with halves swapped
  always_comb begin
    is_real     = (slot_q == p_q);
    ops_active  = (state_q == S_LAUNCH) || (state_q == S_ARM) ||
                  (state_q == S_RUN)    || (state_q == S_NEXT);
    dummy_key   = KEY_W'({dmy_q[HALF-1:0], dmy_q[DATA_W-1:HALF]});
    core_key_o  = '0;
    core_data_o = '0;
    if (ops_active) begin
      core_key_o  = is_real ? key_q : dummy_key;
      core_data_o = is_real ? dat_q : dmy_q;
    end
    core_load_o = (state_q == S_LAUNCH);
    done_o      = (state_q == S_FINISH);
    busy_o      = (state_q != S_IDLE);
    data_o      = res_q;
  end

  // Next-state logic for the job sequencer; the LFSR free-runs in every state
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_step;
    key_d      = key_q;
    dat_d      = dat_q;
    dmy_d      = dmy_q;
    res_d      = res_q;
    n_d        = n_q;
    p_d        = p_q;
    slot_d     = slot_q;
    draw_cnt_d = draw_cnt_q;
    arm_cnt_d  = arm_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (seed_we_i) begin
          lfsr_d = (seed_i == 32'h0) ? SEED : seed_i;
        end
        if (start_i) begin
          key_d      = key_i;
          dat_d      = data_i;
          n_d        = n_sel;
          p_d        = p_sel;
          slot_d     = '0;
          draw_cnt_d = 2'd0;
          state_d    = S_DRAW;
        end
      end
      S_DRAW: begin
        dmy_d      = {dmy_q[DATA_W-33:0], lfsr_q};
        draw_cnt_d = draw_cnt_q + 2'd1;
        if (draw_cnt_q == 2'd3) begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        arm_cnt_d = 1'b0;
        state_d   = S_ARM;
      end
      S_ARM: begin
        // A core that never raises busy is treated as having finished already
        if (core_busy_i) begin
          state_d = S_RUN;
        end else if (arm_cnt_q) begin
          state_d = S_NEXT;
        end else begin
          arm_cnt_d = 1'b1;
        end
      end
      S_RUN: begin
        if (!core_busy_i) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (is_real) begin
          res_d = core_res_i;
        end
        if (slot_q == n_q) begin
          state_d = S_FINISH;
        end else begin
          slot_d     = slot_q + 1'b1;
          draw_cnt_d = 2'd0;
          state_d    = S_DRAW;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any job in flight and clears the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      key_q      <= '0;
      dat_q      <= '0;
      dmy_q      <= '0;
      res_q      <= '0;
      n_q        <= '0;
      p_q        <= '0;
      slot_q     <= '0;
      draw_cnt_q <= 2'd0;
      arm_cnt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      key_q      <= key_d;
      dat_q      <= dat_d;
      dmy_q      <= dmy_d;
      res_q      <= res_d;
      n_q        <= n_d;
      p_q        <= p_d;
      slot_q     <= slot_d;
      draw_cnt_q <= draw_cnt_d;
      arm_cnt_q  <= arm_cnt_d;
    end
  end

endmodule
